fi_fairness_mon: RTL and testbench

- Parametrised, synthesisable fairness monitor for formal and simulation stimulus engines: N independent request/grant + receive/acknowledge channels (imem, dmem, rng, ...).
- Per channel it tracks:
  - outstanding transactions,
  - grant stall,
  - response latency,
  - orphan responses.
- Exposes a combinational per-channel fair vector for the harness to restrict/assume on, plus sticky violation causes for simulation benches.
- Sits beside the core in the RVFI harness and replaces per-interface hand-written counters.

---
 rtl/fi_fairness_pkg.sv | 16 +
 rtl/fi_fairness_mon_if.sv | 13 +
 rtl/fi_fairness_chan.sv | 97 +++++++++
 rtl/fi_fairness_mon.sv | 48 ++++
 tb/tb_fi_fairness_mon.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fi_fairness_pkg.sv
// Shared constants for the fairness monitor: cause bit positions and
// the outstanding-counter width helper.
package fi_fairness_pkg;

    localparam int unsigned CAUSE_STALL  = 0;
    localparam int unsigned CAUSE_LAT    = 1;
    localparam int unsigned CAUSE_ORPHAN = 2;
    localparam int unsigned CAUSE_OVF    = 3;
    localparam int unsigned CAUSE_W      = 4;

    // One spare code above MAX_OUT so overflow is representable.
    function automatic int unsigned out_width(input int unsigned max_out);
        return $clog2(max_out + 2);
    endfunction

endpackage

// File: rtl/fi_fairness_mon_if.sv
// Per-channel request/grant and response/acknowledge signals observed by
// the fairness monitor; the harness drives them, the monitor only listens.
interface fi_fairness_mon_if #(
    parameter int unsigned NCH = 3
);
    logic [NCH-1:0] ch_req;
    logic [NCH-1:0] ch_gnt;
    logic [NCH-1:0] ch_recv;
    logic [NCH-1:0] ch_ack;

    modport master (output ch_req, output ch_gnt, output ch_recv, output ch_ack);
    modport slave  (input  ch_req, input  ch_gnt, input  ch_recv, input  ch_ack);
endinterface

// File: rtl/fi_fairness_chan.sv
// One monitored channel: outstanding/stall/latency counters, the
// combinational fair term and the sticky violation causes.
module fi_fairness_chan
    import fi_fairness_pkg::*;
#(
    parameter int unsigned MAX_STALL = 3,
    parameter int unsigned MAX_OUT   = 3,
    parameter int unsigned MAX_LAT   = 5,
    parameter int unsigned LAT_MODE  = 1,
    parameter int unsigned OW        = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               i_req,
    input  logic               i_gnt,
    input  logic               i_recv,
    input  logic               i_ack,
    input  logic               i_clr,
    output logic               o_fair,
    output logic               o_viol,
    output logic [CAUSE_W-1:0] o_cause,
    output logic [OW-1:0]      o_outstanding
);

    localparam int unsigned SW = $clog2(MAX_STALL + 1);
    localparam int unsigned LW = $clog2(MAX_LAT + 2);
    localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);
    localparam logic [LW-1:0] LAT_LIM   = LW'(MAX_LAT);
    localparam logic [OW-1:0] OUT_LIM   = OW'(MAX_OUT);

    logic [OW-1:0]      r_out;
    logic [SW-1:0]      r_stall;
    logic [LW-1:0]      r_lat;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_viol;

    logic               w_req_hs;
    logic               w_rsp_hs;
    logic [OW-1:0]      w_out_nxt;
    logic [SW-1:0]      w_stall_nxt;
    logic [LW-1:0]      w_lat_nxt;
    logic [CAUSE_W-1:0] w_cause_now;

    assign w_req_hs = i_req && i_gnt;
    assign w_rsp_hs = i_recv && i_ack;

    // A response at zero outstanding is an orphan and never decrements, so
    // a coincident grant still counts; with work in flight they cancel.
    always_comb begin
        w_out_nxt = r_out;
        if (w_req_hs && !(w_rsp_hs && r_out != '0)) begin
            if (r_out != '1) w_out_nxt = r_out + OW'(1);
        end else if (!w_req_hs && w_rsp_hs && r_out != '0) begin
            w_out_nxt = r_out - OW'(1);
        end
    end

    always_comb begin
        w_stall_nxt = '0;
        if (i_req && !i_gnt) w_stall_nxt = (r_stall == '1) ? r_stall : r_stall + SW'(1);
    end

    always_comb begin
        w_lat_nxt = (r_lat == '1) ? r_lat : r_lat + LW'(1);
        if (r_out == '0 || (LAT_MODE != 0 && w_rsp_hs)) w_lat_nxt = '0;
    end

    always_comb begin
        w_cause_now               = '0;
        w_cause_now[CAUSE_STALL]  = r_stall >= STALL_LIM;
        w_cause_now[CAUSE_LAT]    = r_lat > LAT_LIM;
        w_cause_now[CAUSE_ORPHAN] = i_recv && (r_out == '0);
        w_cause_now[CAUSE_OVF]    = r_out > OUT_LIM;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_out   <= '0;
            r_stall <= '0;
            r_lat   <= '0;
            r_cause <= '0;
            r_viol  <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_stall <= w_stall_nxt;
            r_lat   <= w_lat_nxt;
            r_cause <= (i_clr ? '0 : r_cause) | w_cause_now;
            r_viol  <= (i_clr ? 1'b0 : r_viol) | (|w_cause_now);
        end
    end

    assign o_fair        = ~|w_cause_now;
    assign o_viol        = r_viol;
    assign o_cause       = r_cause;
    assign o_outstanding = r_out;

endmodule

// File: rtl/fi_fairness_mon.sv
// Fairness monitor top: one fi_fairness_chan per channel, packed outputs
// and the all-channels-fair reduction.
module fi_fairness_mon
    import fi_fairness_pkg::*;
#(
    parameter int unsigned NCH       = 3,
    parameter int unsigned MAX_STALL = 3,
    parameter int unsigned MAX_OUT   = 3,
    parameter int unsigned MAX_LAT   = 5,
    parameter int unsigned LAT_MODE  = 1,
    localparam int unsigned OW       = out_width(MAX_OUT)
) (
    input  logic                   clock,
    input  logic                   resetn,
    fi_fairness_mon_if.slave       mon,
    input  logic                   clr_sticky,
    output logic [NCH-1:0]         fair,
    output logic                   all_fair,
    output logic [NCH-1:0]         viol,
    output logic [CAUSE_W*NCH-1:0] cause,
    output logic [OW*NCH-1:0]      outstanding
);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        fi_fairness_chan #(
            .MAX_STALL (MAX_STALL),
            .MAX_OUT   (MAX_OUT),
            .MAX_LAT   (MAX_LAT),
            .LAT_MODE  (LAT_MODE),
            .OW        (OW)
        ) u_chan (
            .clock         (clock),
            .resetn        (resetn),
            .i_req         (mon.ch_req[g]),
            .i_gnt         (mon.ch_gnt[g]),
            .i_recv        (mon.ch_recv[g]),
            .i_ack         (mon.ch_ack[g]),
            .i_clr         (clr_sticky),
            .o_fair        (fair[g]),
            .o_viol        (viol[g]),
            .o_cause       (cause[g*CAUSE_W +: CAUSE_W]),
            .o_outstanding (outstanding[g*OW +: OW])
        );
    end

    assign all_fair = &fair;

endmodule

// File: tb/tb_fi_fairness_mon.sv
// Directed bench for fi_fairness_mon: a vector table for single-cycle
// behaviour plus hand sequences for latency modes and asynchronous reset.
module tb_fi_fairness_mon;
    import fi_fairness_pkg::*;

    localparam int unsigned NCH = 3;
    localparam int unsigned OW  = 3;

    typedef struct packed {
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic [2:0]  recv;
        logic [2:0]  ack;
        logic        clr;
        logic [2:0]  fair;
        logic [2:0]  viol;
        logic [11:0] cause;
        logic [8:0]  outs;
    } vec_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic clr_sticky = 1'b0;

    logic [NCH-1:0]         fair1, viol1, fair0, viol0;
    logic                   all1, all0;
    logic [CAUSE_W*NCH-1:0] cause1, cause0;
    logic [OW*NCH-1:0]      outs1, outs0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clock = ~clock;

    fi_fairness_mon_if #(.NCH(NCH)) bus ();

    fi_fairness_mon #(
        .NCH(NCH), .MAX_STALL(3), .MAX_OUT(3), .MAX_LAT(5), .LAT_MODE(1)
    ) dut1 (
        .clock(clock), .resetn(resetn), .mon(bus.slave), .clr_sticky(clr_sticky),
        .fair(fair1), .all_fair(all1), .viol(viol1), .cause(cause1), .outstanding(outs1)
    );

    fi_fairness_mon #(
        .NCH(NCH), .MAX_STALL(3), .MAX_OUT(3), .MAX_LAT(5), .LAT_MODE(0)
    ) dut0 (
        .clock(clock), .resetn(resetn), .mon(bus.slave), .clr_sticky(clr_sticky),
        .fair(fair0), .all_fair(all0), .viol(viol0), .cause(cause0), .outstanding(outs0)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] req, gnt, recv, ack, input logic clr);
        bus.ch_req  = req;
        bus.ch_gnt  = gnt;
        bus.ch_recv = recv;
        bus.ch_ack  = ack;
        clr_sticky  = clr;
    endtask

    function automatic vec_t mk(input logic [2:0] req, gnt, recv, ack, input logic clr,
                                input logic [2:0] f, v, input logic [11:0] c, input logic [8:0] o);
        vec_t t;
        t.req = req; t.gnt = gnt; t.recv = recv; t.ack = ack; t.clr = clr;
        t.fair = f; t.viol = v; t.cause = c; t.outs = o;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vq[$];
        vec_t        v;
        logic [11:0] exp_m0;

        // Stall on ch0, then grant
        vq.push_back(mk(3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'h6, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b001, 3'b001, 3'b000, 3'b000, 1'b0, 3'h6, 3'h1, 12'h001, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h1, 12'h001, 9'h001));
        vq.push_back(mk(3'b000, 3'b000, 3'b001, 3'b001, 1'b0, 3'h7, 3'h1, 12'h001, 9'h001));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h1, 12'h001, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'h7, 3'h1, 12'h001, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        // Stall on ch2 with clear racing an active cause
        vq.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 1'b1, 3'h3, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h3, 3'h4, 12'h100, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h4, 12'h100, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'h7, 3'h4, 12'h100, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        // Outstanding up to overflow on ch1, then drain
        vq.push_back(mk(3'b010, 3'b010, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b010, 3'b010, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h008));
        vq.push_back(mk(3'b010, 3'b010, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h010));
        vq.push_back(mk(3'b010, 3'b010, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h018));
        vq.push_back(mk(3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 3'h5, 3'h0, 12'h000, 9'h020));
        vq.push_back(mk(3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 3'h7, 3'h2, 12'h080, 9'h018));
        vq.push_back(mk(3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 3'h7, 3'h2, 12'h080, 9'h010));
        vq.push_back(mk(3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 3'h7, 3'h2, 12'h080, 9'h008));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h2, 12'h080, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'h7, 3'h2, 12'h080, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h0, 12'h000, 9'h000));
        // Orphan with coincident grant on ch2, then plain orphan on ch0
        vq.push_back(mk(3'b100, 3'b100, 3'b100, 3'b100, 1'b0, 3'h3, 3'h0, 12'h000, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h4, 12'h400, 9'h040));
        vq.push_back(mk(3'b000, 3'b000, 3'b100, 3'b100, 1'b0, 3'h7, 3'h4, 12'h400, 9'h040));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h4, 12'h400, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b001, 3'b000, 1'b0, 3'h6, 3'h4, 12'h400, 9'h000));
        vq.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'h7, 3'h5, 12'h404, 9'h000));

        drive(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        #2;
        check("rst_fair",  16'(fair1),  16'h7);
        check("rst_viol",  16'(viol1),  16'h0);
        check("rst_cause", 16'(cause1), 16'h000);
        check("rst_outs",  16'(outs1),  16'h000);
        bus.ch_recv = 3'b010;
        #1;
        check("rst_orphan_fair", 16'(fair1), 16'h5);
        bus.ch_recv = 3'b000;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        foreach (vq[k]) begin
            v = vq[k];
            @(negedge clock);
            drive(v.req, v.gnt, v.recv, v.ack, v.clr);
            #1;
            check($sformatf("v%0d_fair", k),  16'(fair1),  16'(v.fair));
            check($sformatf("v%0d_all", k),   16'(all1),   16'(&v.fair));
            check($sformatf("v%0d_viol", k),  16'(viol1),  16'(v.viol));
            check($sformatf("v%0d_cause", k), 16'(cause1), 16'(v.cause));
            check($sformatf("v%0d_outs", k),  16'(outs1),  16'(v.outs));
        end

        // Latency: grants in cycles 0,1; responses in cycles 5,9 on ch0
        @(negedge clock);
        drive(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        exp_m0 = 12'h87F;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (c < 2)           drive(3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
            else if (c == 5 || c == 9) drive(3'b000, 3'b000, 3'b001, 3'b001, 1'b0);
            else                 drive(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            #1;
            check($sformatf("lat_m1_c%0d_fair", c), 16'(fair1), 16'h7);
            check($sformatf("lat_m0_c%0d_fair", c), 16'(fair0), 16'({2'b11, exp_m0[c]}));
        end
        check("lat_m0_cause", 16'(cause0), 16'h002);
        check("lat_m0_viol",  16'(viol0),  16'h1);
        check("lat_m1_cause", 16'(cause1), 16'h000);
        check("lat_m1_outs",  16'(outs1),  16'h000);

        // Asynchronous reset with outstanding=2, lat=3 on ch0
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c < 2) drive(3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
            else       drive(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        end
        @(negedge clock);
        #1;
        check("pre_rst_outs", 16'(outs1), 16'h002);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_outs1",  16'(outs1),  16'h000);
        check("arst_outs0",  16'(outs0),  16'h000);
        check("arst_fair1",  16'(fair1),  16'h7);
        check("arst_viol0",  16'(viol0),  16'h0);
        check("arst_cause0", 16'(cause0), 16'h000);
        bus.ch_recv = 3'b001;
        bus.ch_ack  = 3'b001;
        #1;
        check("arst_orphan_fair", 16'(fair1), 16'h6);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("post_rst_orphan_fair", 16'(fair1), 16'h6);
        @(negedge clock);
        drive(3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        #1;
        check("post_rst_cause", 16'(cause1), 16'h004);
        check("post_rst_viol",  16'(viol1),  16'h1);
        check("post_rst_outs",  16'(outs1),  16'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
